// File: rtl/branch_cond_unit.sv
// Branch condition unit: flag register, 8-way condition evaluation, post-branch flush window, saturating stats.
// Latency: take is combinational in the branch cycle; flush/flags/counters update on the next clock edge.
// Backpressure: none; while flush is high, incoming branches are ignored (not taken, not counted).
module branch_cond_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_carry,
  input  logic             flag_we,
  input  logic             branch,
  input  logic [2:0]       cond,
  input  logic             stat_clr,
  output logic             take,
  output logic             flush,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0]       FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] eff_flags;
  logic       cond_true;

  // Flags written this cycle are forwarded so a compare-and-branch pair needs no bubble.
  assign eff_flags = flag_we ? {alu_neg, alu_carry, alu_zero} : flags;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = eff_flags[0];
      3'd2:    cond_true = ~eff_flags[0];
      3'd3:    cond_true = eff_flags[2];
      3'd4:    cond_true = ~eff_flags[2];
      3'd5:    cond_true = eff_flags[1];
      3'd6:    cond_true = ~eff_flags[1];
      default: cond_true = 1'b0;
    endcase
  end

  assign flush = (state == FLUSH);
  assign take  = reset & branch & ~flush & cond_true;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (take && (FLUSH_CYCLES > 0)) begin
          state_nxt = FLUSH;
          cnt_nxt   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      flags        <= 3'b000;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flag_we) flags <= {alu_neg, alu_carry, alu_zero};
      if (stat_clr) begin
        branch_count <= '0;
        taken_count  <= '0;
      end else begin
        if (branch && !flush && branch_count != CNT_MAX) branch_count <= branch_count + 1'b1;
        if (take && taken_count != CNT_MAX)              taken_count  <= taken_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench: three differently parameterised instances share one stimulus stream and are compared every cycle
// against a per-instance behavioural model (remaining-flush-cycles counter, saturating integer counts).
module tb_branch_cond_unit;

  logic       clock = 1'b0;
  logic       reset, alu_zero, alu_neg, alu_carry, flag_we, branch, stat_clr;
  logic [2:0] cond;

  logic        take0, take1, take2, flush0, flush1, flush2;
  logic [2:0]  flags0, flags1, flags2;
  logic [15:0] bc0, tc0;
  logic [1:0]  bc1, tc1;
  logic [2:0]  bc2, tc2;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int NI = 3;
  int         fl_cfg [NI] = '{2, 0, 4};
  int         cw_cfg [NI] = '{16, 2, 3};
  logic [2:0] m_flags[NI];
  int         m_left [NI];
  int         m_bc   [NI];
  int         m_tc   [NI];

  always #5 clock = ~clock;

  branch_cond_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) u0 (
    .clock(clock), .reset(reset), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry),
    .flag_we(flag_we), .branch(branch), .cond(cond), .stat_clr(stat_clr),
    .take(take0), .flush(flush0), .flags(flags0), .branch_count(bc0), .taken_count(tc0));

  branch_cond_unit #(.FLUSH_CYCLES(0), .CNT_W(2)) u1 (
    .clock(clock), .reset(reset), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry),
    .flag_we(flag_we), .branch(branch), .cond(cond), .stat_clr(stat_clr),
    .take(take1), .flush(flush1), .flags(flags1), .branch_count(bc1), .taken_count(tc1));

  branch_cond_unit #(.FLUSH_CYCLES(4), .CNT_W(3)) u2 (
    .clock(clock), .reset(reset), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry),
    .flag_we(flag_we), .branch(branch), .cond(cond), .stat_clr(stat_clr),
    .take(take2), .flush(flush2), .flags(flags2), .branch_count(bc2), .taken_count(tc2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit cond_holds(input logic [2:0] c, input logic [2:0] f);
    bit n = f[2], cy = f[1], z = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return cy;
      3'd6: return !cy;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_take(input int i);
    logic [2:0] eff;
    if (!reset) return 1'b0;
    eff = flag_we ? {alu_neg, alu_carry, alu_zero} : m_flags[i];
    return branch && (m_left[i] == 0) && cond_holds(cond, eff);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      bit t, in_flush;
      int maxv;
      maxv     = (1 << cw_cfg[i]) - 1;
      t        = exp_take(i);
      in_flush = (m_left[i] > 0);
      if (!reset) begin
        m_flags[i] = 3'b000; m_left[i] = 0; m_bc[i] = 0; m_tc[i] = 0;
      end else begin
        if (flag_we) m_flags[i] = {alu_neg, alu_carry, alu_zero};
        if (in_flush)                  m_left[i] = m_left[i] - 1;
        else if (t && fl_cfg[i] > 0)   m_left[i] = fl_cfg[i];
        if (stat_clr) begin
          m_bc[i] = 0; m_tc[i] = 0;
        end else begin
          if (branch && !in_flush && m_bc[i] < maxv) m_bc[i]++;
          if (t && m_tc[i] < maxv)                   m_tc[i]++;
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic tk, input logic fl, input logic [2:0] fg,
                            input logic [31:0] bc, input logic [31:0] tc);
    check($sformatf("u%0d.take", i),  32'(tk), 32'(exp_take(i)));
    check($sformatf("u%0d.flush", i), 32'(fl), 32'(m_left[i] > 0));
    check($sformatf("u%0d.flags", i), 32'(fg), 32'(m_flags[i]));
    check($sformatf("u%0d.branch_count", i), bc, 32'(m_bc[i]));
    check($sformatf("u%0d.taken_count", i),  tc, 32'(m_tc[i]));
  endtask

  task automatic cyc(input logic r, input logic fwe, input logic z, input logic n, input logic c,
                     input logic br, input logic [2:0] cd, input logic sc);
    reset = r; flag_we = fwe; alu_zero = z; alu_neg = n; alu_carry = c;
    branch = br; cond = cd; stat_clr = sc;
    #4;
    check_inst(0, take0, flush0, flags0, 32'(bc0), 32'(tc0));
    check_inst(1, take1, flush1, flags1, 32'(bc1), 32'(tc1));
    check_inst(2, take2, flush2, flags2, 32'(bc2), 32'(tc2));
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; flag_we = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; alu_carry = 1'b0;
    branch = 1'b0; cond = 3'd0; stat_clr = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_flags[i] = 3'b000; m_left[i] = 0; m_bc[i] = 0; m_tc[i] = 0;
    end
    @(posedge clock);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);

    // Legacy AND gate truth table: {alu_zero, branch} with forwarding, cond EQ.
    for (int k = 0; k < 4; k++) begin
      logic [1:0] v;
      v = 2'(k);
      cyc(1'b1, 1'b1, v[1], 1'b0, 1'b0, v[0], 3'd1, 1'b0);
      idle(5);
    end

    // Forwarded flag overrides registered flag, then registered flag is used.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    idle(5);

    // Flush window: taken branch followed by always-branches inside the window.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    idle(5);

    // All conditions against N=1, C=0, Z=1.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'(k), 1'b0);
      idle(5);
    end

    // Saturation and clear-with-branch priority.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    idle(5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    idle(2);

    // Reset in the middle of a flush window, with a branch held during reset.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    idle(3);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
          3'($urandom_range(0, 7)), ($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
